// File: rtl/tm1638_responder.sv
// -----------------------------------------------------------------------------
// tm1638_responder
//   Device-side end of the TM1638 three-wire serial link. It emulates a TM1638
//   chip so a host driver can be brought up or loop-tested against it. It
//   decodes command frames framed by stb_n low and stores 16x8 display RAM plus
//   display control. For key-read commands it shifts key-scan bytes back on DIO.
//   All bytes travel LSB first.
//
// Parameters
//   SYNC_STAGES  flops in each stb_n/sclk/dio input synchroniser (>=2)
//   KEY_BYTES    bytes returned per key-read frame
//
// Ports
//   clk, rst     system clock, asynchronous active-high reset
//   stb_n        frame strobe from host (active low)
//   sclk_in      serial clock from host (idles high)
//   dio_in       serial data from host
//   dio_out      serial data to host, valid while dio_oe=1
//   dio_oe       DIO drive enable, high only while key bits are being shifted
//   keys         key-scan data, keys[0] is the first bit sent
//   rd_addr      display RAM read address
//   rd_data      display RAM content at rd_addr (combinational)
//   display_on   display-control bit 3
//   brightness   display-control bits [2:0]
//   frame_err    one-clk pulse when stb_n rises with a partial byte received
//
// Configuration
//   TM1638_RESP_KEY_LATCH_EN  when defined, keys are snapshotted on the clk that
//   decodes the read command, and the frame shifts out that snapshot. When it is
//   undefined, each bit is taken live from keys at its sclk falling edge.
// -----------------------------------------------------------------------------
module tm1638_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int KEY_BYTES   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stb_n,
  input  logic                   sclk_in,
  input  logic                   dio_in,
  output logic                   dio_out,
  output logic                   dio_oe,
  input  logic [8*KEY_BYTES-1:0] keys,
  input  logic [3:0]             rd_addr,
  output logic [7:0]             rd_data,
  output logic                   display_on,
  output logic [2:0]             brightness,
  output logic                   frame_err
);

  localparam int KEY_BITS = 8 * KEY_BYTES;
  localparam int BYTE_W   = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_WDATA  = 3'd2,
    S_RDATA  = 3'd3,
    S_IGNORE = 3'd4
  } state_t;

  state_t state_r, state_nxt_s;

  logic [SYNC_STAGES-1:0] stb_sync_r, sclk_sync_r, dio_sync_r;
  logic stb_prev_r, sclk_prev_r;
  logic stb_s, sclk_s, dio_s;
  logic stb_fall_s, stb_rise_s, sclk_rise_s, sclk_fall_s;

  logic [2:0]        bit_cnt_r;
  logic [BYTE_W-1:0] byte_cnt_r;
  logic [6:0]        sr_r;
  logic [7:0]        byte_s;
  logic [3:0]        addr_r;
  logic              fixed_addr_r;
  logic [7:0]        ram_r [16];

  logic bit_rise_s, byte_done_s, cmd_done_s, ram_we_s;
  logic rd_start_s, rd_last_s, rd_shift_s, err_s;

  logic [KEY_BITS-1:0] keys_src_s;
  logic [BYTE_W+2:0]   key_idx_s;

  assign stb_s  = stb_sync_r[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_r[SYNC_STAGES-1];
  assign dio_s  = dio_sync_r[SYNC_STAGES-1];

  assign stb_fall_s  = stb_prev_r & ~stb_s;
  assign stb_rise_s  = ~stb_prev_r & stb_s;
  assign sclk_rise_s = ~sclk_prev_r & sclk_s;
  assign sclk_fall_s = sclk_prev_r & ~sclk_s;

  // The byte being completed: the newest bit lands in the MSB.
  assign byte_s    = {dio_s, sr_r};
  assign key_idx_s = {byte_cnt_r, bit_cnt_r};
  assign rd_data   = ram_r[rd_addr];

  // Input synchronisers plus previous-value flops used for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stb_sync_r  <= '1;
      sclk_sync_r <= '1;
      dio_sync_r  <= '0;
      stb_prev_r  <= 1'b1;
      sclk_prev_r <= 1'b1;
    end else begin
      stb_sync_r  <= {stb_sync_r[SYNC_STAGES-2:0], stb_n};
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk_in};
      dio_sync_r  <= {dio_sync_r[SYNC_STAGES-2:0], dio_in};
      stb_prev_r  <= stb_s;
      sclk_prev_r <= sclk_s;
    end
  end

  // Frame state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a strobe rise always returns to idle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (stb_fall_s) state_nxt_s = S_CMD;
        else            state_nxt_s = S_IDLE;
      end
      S_CMD: begin
        if (stb_rise_s) begin
          state_nxt_s = S_IDLE;
        end else if (cmd_done_s) begin
          case (byte_s[7:6])
            2'b01:   state_nxt_s = byte_s[1] ? S_RDATA : S_IGNORE;
            2'b11:   state_nxt_s = S_WDATA;
            default: state_nxt_s = S_IGNORE;
          endcase
        end else begin
          state_nxt_s = S_CMD;
        end
      end
      S_WDATA: begin
        if (stb_rise_s) state_nxt_s = S_IDLE;
        else            state_nxt_s = S_WDATA;
      end
      S_RDATA: begin
        if (stb_rise_s)     state_nxt_s = S_IDLE;
        else if (rd_last_s) state_nxt_s = S_IGNORE;
        else                state_nxt_s = S_RDATA;
      end
      S_IGNORE: begin
        if (stb_rise_s) state_nxt_s = S_IDLE;
        else            state_nxt_s = S_IGNORE;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Per-clk action strobes derived from state and synced edges.
  always_comb begin
    bit_rise_s  = sclk_rise_s & (state_r != S_IDLE) & ~stb_rise_s;
    byte_done_s = bit_rise_s & (bit_cnt_r == 3'd7);
    cmd_done_s  = byte_done_s & (state_r == S_CMD);
    ram_we_s    = byte_done_s & (state_r == S_WDATA);
    rd_start_s  = cmd_done_s & (byte_s[7:6] == 2'b01) & byte_s[1];
    rd_last_s   = byte_done_s & (state_r == S_RDATA) &
                  (byte_cnt_r == BYTE_W'(KEY_BYTES - 1));
    rd_shift_s  = sclk_fall_s & (state_r == S_RDATA) & ~stb_rise_s;
    err_s       = stb_rise_s & (bit_cnt_r != 3'd0) &
                  ((state_r == S_CMD) | (state_r == S_WDATA));
  end

  // Bit/byte counters and receive shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= '0;
      sr_r       <= 7'd0;
    end else if (stb_rise_s) begin
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= '0;
    end else if (bit_rise_s) begin
      sr_r      <= byte_s[7:1];
      bit_cnt_r <= bit_cnt_r + 3'd1;
      // The byte count only indexes key bits, so it advances in read mode only.
      if ((state_r == S_RDATA) && (bit_cnt_r == 3'd7)) begin
        byte_cnt_r <= byte_cnt_r + BYTE_W'(1);
      end
    end
  end

  // Command decode: data mode, display control and address pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fixed_addr_r <= 1'b0;
      display_on   <= 1'b0;
      brightness   <= 3'd0;
      addr_r       <= 4'd0;
    end else if (cmd_done_s) begin
      case (byte_s[7:6])
        2'b01: fixed_addr_r <= byte_s[2];
        2'b10: begin
          display_on <= byte_s[3];
          brightness <= byte_s[2:0];
        end
        2'b11: addr_r <= byte_s[3:0];
        default: ;
      endcase
    end else if (ram_we_s && !fixed_addr_r) begin
      addr_r <= addr_r + 4'd1;
    end
  end

  // Display RAM, written with each complete data byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) ram_r[i] <= 8'h00;
    end else if (ram_we_s) begin
      ram_r[addr_r] <= byte_s;
    end
  end

`ifdef TM1638_RESP_KEY_LATCH_EN
  logic [KEY_BITS-1:0] key_snap_r;

  // Key snapshot taken on the clk that decodes the read command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_snap_r <= '0;
    end else if (rd_start_s) begin
      key_snap_r <= keys;
    end
  end

  assign keys_src_s = key_snap_r;
`else
  assign keys_src_s = keys;
`endif

  // Key-read output drive and the frame error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dio_out   <= 1'b0;
      dio_oe    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err_s;
      if (stb_rise_s || rd_last_s) begin
        dio_oe <= 1'b0;
      end else if (rd_start_s) begin
        dio_oe <= 1'b1;
      end
      if (rd_shift_s) begin
        dio_out <= keys_src_s[key_idx_s];
      end
    end
  end

endmodule

// File: tb/tb_tm1638_responder.sv
module tb_tm1638_responder;

  localparam int HALF = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb_n, sclk_in, dio_in;
  logic        dio_out, dio_oe;
  logic [31:0] keys;
  logic [3:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        display_on;
  logic [2:0]  brightness;
  logic        frame_err;

  tm1638_responder #(.SYNC_STAGES(2), .KEY_BYTES(4)) dut (
    .clk(clk), .rst(rst), .stb_n(stb_n), .sclk_in(sclk_in), .dio_in(dio_in),
    .dio_out(dio_out), .dio_oe(dio_oe), .keys(keys), .rd_addr(rd_addr),
    .rd_data(rd_data), .display_on(display_on), .brightness(brightness),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int ferr_seen = 0;

  // Reference model state
  logic [7:0] m_ram [16];
  logic [3:0] m_addr;
  logic       m_fixed, m_on;
  logic [2:0] m_br;
  int         m_ferr = 0;

  logic [7:0] tx_q [$];

  // Count clks during which frame_err is high (a proper pulse adds exactly 1).
  always @(negedge clk) if (frame_err) ferr_seen <= ferr_seen + 1;

  initial begin
    #900000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic half_wait();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
    m_addr = 4'd0; m_fixed = 1'b0; m_on = 1'b0; m_br = 3'd0;
  endtask

  // Send nbits of b, LSB first; optionally raise stb_n together with the last rise.
  task automatic send_byte(input logic [7:0] b, input int nbits, input bit last_with_stb);
    for (int i = 0; i < nbits; i++) begin
      sclk_in = 1'b0;
      dio_in  = b[i];
      half_wait();
      sclk_in = 1'b1;
      if (last_with_stb && (i == nbits - 1)) stb_n = 1'b1;
      half_wait();
    end
  endtask

  // Apply a completed host frame (tx_q plus pbits of a discarded byte) to the model.
  task automatic model_frame(input int pbits);
    logic [7:0] cmd;
    bit in_wdata;
    in_wdata = 1'b0;
    if (tx_q.size() == 0) begin
      if (pbits > 0) m_ferr++;
    end else begin
      cmd = tx_q[0];
      case (cmd[7:6])
        2'b01: m_fixed = cmd[2];
        2'b10: begin m_on = cmd[3]; m_br = cmd[2:0]; end
        2'b11: begin m_addr = cmd[3:0]; in_wdata = 1'b1; end
        default: ;
      endcase
      if (in_wdata) begin
        for (int j = 1; j < tx_q.size(); j++) begin
          m_ram[m_addr] = tx_q[j];
          if (!m_fixed) m_addr = m_addr + 4'd1;
        end
        if (pbits > 0) m_ferr++;
      end
    end
  endtask

  task automatic send_frame(input int pbits, input logic [7:0] pval);
    stb_n = 1'b0;
    half_wait();
    for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], 8, 1'b0);
    if (pbits > 0) send_byte(pval, pbits, pbits == 8);
    stb_n = 1'b1;
    half_wait();
    half_wait();
    model_frame(pbits);
  endtask

  task automatic check_ram(input string tag, input logic [3:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1;
    check_eq(tag, 64'(rd_data), 64'(exp));
  endtask

  task automatic check_all();
    check_eq("display_on", 64'(display_on), 64'(m_on));
    check_eq("brightness", 64'(brightness), 64'(m_br));
    check_eq("frame_err_cnt", 64'(ferr_seen), 64'(m_ferr));
    check_eq("dio_oe_idle", 64'(dio_oe), 64'd0);
    for (int i = 0; i < 16; i++) check_ram("ram", 4'(i), m_ram[i]);
  endtask

  // Key-read frame: 40 host clocks; keys switch to k1 before bit 16 when chg=1.
  task automatic host_read(input logic [31:0] k0, input logic [31:0] k1, input bit chg, input bit fixbit);
    logic [39:0] got_bits, got_oe;
    logic [31:0] exp_keys;
    logic [7:0]  cmd;
    cmd = 8'h42 | {5'd0, fixbit, 2'd0};
    keys = k0;
    stb_n = 1'b0;
    half_wait();
    send_byte(cmd, 8, 1'b0);
    m_fixed = fixbit;
    dio_in = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (chg && i == 16) keys = k1;
      sclk_in = 1'b0;
      half_wait();
      got_bits[i] = dio_out;
      got_oe[i]   = dio_oe;
      sclk_in = 1'b1;
      half_wait();
    end
    stb_n = 1'b1;
    half_wait();
    half_wait();
`ifdef TM1638_RESP_KEY_LATCH_EN
    exp_keys = k0;
`else
    exp_keys = chg ? {k1[31:16], k0[15:0]} : k0;
`endif
    for (int b = 0; b < 4; b++) check_eq("rd_byte", 64'(got_bits[8*b +: 8]), 64'(exp_keys[8*b +: 8]));
    check_eq("rd_oe_mask", 64'(got_oe), 64'h00_FFFF_FFFF);
    check_eq("rd_oe_after", 64'(dio_oe), 64'd0);
  endtask

  initial begin
    int op, len, pb;
    rst = 1'b1; stb_n = 1'b1; sclk_in = 1'b1; dio_in = 1'b0;
    keys = 32'd0; rd_addr = 4'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_dio_out", 64'(dio_out), 64'd0);
    check_eq("rst_frame_err", 64'(frame_err), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all();

    // Incrementing write with wrap
    tx_q = {8'h40}; send_frame(0, 8'h00);
    tx_q = {8'hC0};
    for (int i = 1; i <= 16; i++) tx_q.push_back(8'(i));
    tx_q.push_back(8'hAB);
    send_frame(0, 8'h00);
    check_ram("wrap_ram0", 4'd0, 8'hAB);
    check_ram("wrap_ram1", 4'd1, 8'h02);
    check_ram("wrap_ram15", 4'd15, 8'h10);
    check_all();

    // Fixed-address mode
    tx_q = {8'h44}; send_frame(0, 8'h00);
    tx_q = {8'hC5, 8'h7E, 8'h3C}; send_frame(0, 8'h00);
    check_ram("fixed_ram5", 4'd5, 8'h3C);
    check_ram("fixed_ram6", 4'd6, 8'h07);
    tx_q = {8'h40}; send_frame(0, 8'h00);
    check_all();

    // Display control
    tx_q = {8'h8F}; send_frame(0, 8'h00);
    check_eq("disp_on_8f", 64'(display_on), 64'd1);
    check_eq("bright_8f", 64'(brightness), 64'd7);
    tx_q = {8'h88}; send_frame(0, 8'h00);
    check_eq("bright_88", 64'(brightness), 64'd0);
    check_all();

    // Key reads, static and with keys changing mid-frame
    host_read(32'h04030201, 32'h04030201, 1'b0, 1'b0);
    host_read(32'h04030201, 32'h88770201, 1'b1, 1'b0);

    // Aborted command, then a clean write
    tx_q = {}; send_frame(5, 8'hC3);
    check_all();
    tx_q = {8'hC2, 8'h55}; send_frame(0, 8'h00);
    check_ram("after_abort_ram2", 4'd2, 8'h55);
    check_all();

    // Strobe rise on the same clk as the 8th data rise: byte discarded
    tx_q = {8'hC8, 8'h11}; send_frame(8, 8'h99);
    check_all();

    // Randomised frames
    for (int it = 0; it < 50; it++) begin
      op = $urandom_range(0, 5);
      pb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0;
      tx_q = {};
      case (op)
        0: begin
          tx_q.push_back(8'hC0 | 8'($urandom_range(0, 15)));
          len = $urandom_range(0, 16);
          for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom));
        end
        1: begin
          tx_q.push_back(8'h40 | (8'($urandom) & 8'h3D));
          len = $urandom_range(0, 2);
          for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom));
        end
        2: tx_q.push_back(8'h80 | (8'($urandom) & 8'h3F));
        3: begin
          tx_q.push_back(8'($urandom) & 8'h3F);
          tx_q.push_back(8'($urandom));
        end
        default: ;
      endcase
      if (op == 4) begin
        host_read($urandom, $urandom, 1'($urandom), 1'($urandom));
      end else begin
        if (op == 5 && pb == 0) pb = $urandom_range(1, 7);
        send_frame(pb, 8'($urandom));
      end
      check_all();
    end

    // Reset in the middle of a write frame
    stb_n = 1'b0;
    half_wait();
    send_byte(8'hC0, 8, 1'b0);
    send_byte(8'h5A, 8, 1'b0);
    send_byte(8'hA5, 3, 1'b0);
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    stb_n = 1'b1; sclk_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    half_wait();
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
